// File: rtl/param_datapath.sv
// Accumulator-style datapath: shared bus, seven registers, 8-op ALU with live flags,
// and a fixed-latency single-port memory sequenced by a two-state access FSM.
module param_datapath #(
   parameter int W       = 16,
   parameter int AW      = 12,
   parameter int MEM_LAT = 2
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [2:0]    bus_sel,
   input  logic [6:0]    ld,
   input  logic [6:0]    inc,
   input  logic [6:0]    clr,
   input  logic [2:0]    alu_op,
   input  logic          mem_rd,
   input  logic          mem_wr,
   output logic          mem_busy,
   output logic          mem_done,
   output logic          mem_err,
   output logic [AW-1:0] AR,
   output logic [AW-1:0] PC,
   output logic [W-1:0]  DR,
   output logic [W-1:0]  AC,
   output logic [W-1:0]  IR,
   output logic [W-1:0]  TR,
   output logic [W-1:0]  MDATA,
   output logic          E,
   output logic          CO,
   output logic          OVF,
   output logic          Z,
   output logic          N
);

   localparam int DEPTH = 1 << AW;

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} mem_state_t;

   logic [AW-1:0] r_ar, r_pc;
   logic [W-1:0]  r_dr, r_ac, r_ir, r_tr, r_mdata;
   logic          r_e;

   mem_state_t    r_state;
   logic [2:0]    r_cnt;
   logic [AW-1:0] r_addr;
   logic [W-1:0]  r_wdata;
   logic          r_op_wr;
   logic          r_done;
   logic          r_err;
   logic [W-1:0]  r_mem [0:DEPTH-1];

   logic [W-1:0]  w_bus;
   logic [W-1:0]  w_res;
   logic          w_eout, w_co, w_ovf;
   logic [W:0]    w_sum_add, w_sum_inc;
   logic          w_commit_wr;
   logic          w_unused;

   assign w_sum_add   = {1'b0, r_ac} + {1'b0, r_dr};
   assign w_sum_inc   = {1'b0, r_ac} + {{W{1'b0}}, 1'b1};
   assign w_commit_wr = (r_state == ST_BUSY) && (r_cnt == 3'd0) && r_op_wr;
   // IR and TR have no increment path
   assign w_unused    = ^inc[5:4];

   // Bus source multiplexer
   always_comb begin
      w_bus = {W{1'b0}};
      case (bus_sel)
         3'd0:    w_bus = {W{1'b0}};
         3'd1:    w_bus = W'(r_ar);
         3'd2:    w_bus = W'(r_pc);
         3'd3:    w_bus = r_dr;
         3'd4:    w_bus = r_ac;
         3'd5:    w_bus = r_ir;
         3'd6:    w_bus = r_tr;
         3'd7:    w_bus = r_mdata;
         default: w_bus = {W{1'b0}};
      endcase
   end

   // ALU result, E-out and carry/overflow
   always_comb begin
      w_res  = r_ac;
      w_eout = r_e;
      w_co   = 1'b0;
      w_ovf  = 1'b0;
      case (alu_op)
         3'd0: w_res = r_ac & r_dr;
         3'd1: begin
            w_res  = w_sum_add[W-1:0];
            w_eout = w_sum_add[W];
            w_co   = w_sum_add[W];
            w_ovf  = (r_ac[W-1] == r_dr[W-1]) && (w_sum_add[W-1] != r_ac[W-1]);
         end
         3'd2: w_res = r_dr;
         3'd3: w_res = ~r_ac;
         3'd4: begin
            w_res  = {r_e, r_ac[W-1:1]};
            w_eout = r_ac[0];
         end
         3'd5: begin
            w_res  = {r_ac[W-2:0], r_e};
            w_eout = r_ac[W-1];
         end
         3'd6: w_res = r_ac;
         3'd7: begin
            w_res  = w_sum_inc[W-1:0];
            w_eout = w_sum_inc[W];
            w_co   = w_sum_inc[W];
            w_ovf  = ~r_ac[W-1] & w_sum_inc[W-1];
         end
         default: w_res = r_ac;
      endcase
   end

   assign CO  = w_co;
   assign OVF = w_ovf;
   assign Z   = (w_res == {W{1'b0}});
   assign N   = w_res[W-1];

   // Register file: clear beats load beats increment
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ar <= {AW{1'b0}};
         r_pc <= {AW{1'b0}};
         r_dr <= {W{1'b0}};
         r_ac <= {W{1'b0}};
         r_ir <= {W{1'b0}};
         r_tr <= {W{1'b0}};
         r_e  <= 1'b0;
      end else begin
         if (clr[0])      r_ar <= {AW{1'b0}};
         else if (ld[0])  r_ar <= AW'(w_bus);
         else if (inc[0]) r_ar <= r_ar + AW'(1'b1);

         if (clr[1])      r_pc <= {AW{1'b0}};
         else if (ld[1])  r_pc <= AW'(w_bus);
         else if (inc[1]) r_pc <= r_pc + AW'(1'b1);

         if (clr[2])      r_dr <= {W{1'b0}};
         else if (ld[2])  r_dr <= w_bus;
         else if (inc[2]) r_dr <= r_dr + W'(1'b1);

         if (clr[3])      r_ac <= {W{1'b0}};
         else if (ld[3])  r_ac <= w_res;
         else if (inc[3]) r_ac <= r_ac + W'(1'b1);

         if (clr[4])      r_ir <= {W{1'b0}};
         else if (ld[4])  r_ir <= w_bus;

         if (clr[5])      r_tr <= {W{1'b0}};
         else if (ld[5])  r_tr <= w_bus;

         if (clr[6])      r_e <= 1'b0;
         else if (ld[6])  r_e <= w_eout;
         else if (inc[6]) r_e <= ~r_e;
      end
   end

   // Memory access sequencer; request is latched so AR/bus may change while busy
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= 3'd0;
         r_addr  <= {AW{1'b0}};
         r_wdata <= {W{1'b0}};
         r_op_wr <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_mdata <= {W{1'b0}};
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (mem_rd && mem_wr) begin
                  r_err <= 1'b1;
               end else if (mem_rd || mem_wr) begin
                  r_addr  <= r_ar;
                  r_wdata <= w_bus;
                  r_op_wr <= mem_wr;
                  r_cnt   <= 3'(MEM_LAT - 1);
                  r_state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (mem_rd || mem_wr) begin
                  r_err <= 1'b1;
               end
               if (r_cnt == 3'd0) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
                  if (!r_op_wr) begin
                     r_mdata <= r_mem[r_addr];
                  end
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Storage array is deliberately left out of reset
   always_ff @(posedge clk) begin
      if (w_commit_wr) begin
         r_mem[r_addr] <= r_wdata;
      end
   end

   assign mem_busy = (r_state == ST_BUSY);
   assign mem_done = r_done;
   assign mem_err  = r_err;
   assign AR       = r_ar;
   assign PC       = r_pc;
   assign DR       = r_dr;
   assign AC       = r_ac;
   assign IR       = r_ir;
   assign TR       = r_tr;
   assign MDATA    = r_mdata;
   assign E        = r_e;

endmodule

// File: tb/tb_param_datapath.sv
// Self-checking bench for param_datapath: hand-derived ALU/register table, directed
// memory sequences, and randomized traffic against a cycle-level behavioural model.
module tb_param_datapath;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  bus_sel;
   logic [6:0]  ld, inc, clr;
   logic [2:0]  alu_op;
   logic        mem_rd, mem_wr;
   logic        mem_busy, mem_done, mem_err;
   logic [11:0] AR, PC;
   logic [15:0] DR, AC, IR, TR, MDATA;
   logic        E, CO, OVF, Z, N;

   param_datapath #(.W(16), .AW(12), .MEM_LAT(LAT)) dut (
      .clk(clk), .reset_n(reset_n), .bus_sel(bus_sel), .ld(ld), .inc(inc), .clr(clr),
      .alu_op(alu_op), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_busy(mem_busy),
      .mem_done(mem_done), .mem_err(mem_err), .AR(AR), .PC(PC), .DR(DR), .AC(AC),
      .IR(IR), .TR(TR), .MDATA(MDATA), .E(E), .CO(CO), .OVF(OVF), .Z(Z), .N(N)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   logic [3:0] last_flags;

   // reference model state
   int unsigned m_ar, m_pc, m_dr, m_ac, m_ir, m_tr, m_e, m_md;
   bit          m_mdk, m_err, m_done, m_pend, m_pwr;
   int unsigned m_paddr, m_pdata, m_ta, cyc;
   bit [15:0]   mmem [int];

   typedef struct {
      logic [2:0]  sel;
      logic [6:0]  l, i, c;
      logic [2:0]  op;
      logic [3:0]  flg;
      logic [15:0] ac;
      logic        e;
      logic [15:0] dr;
      logic [11:0] pc;
   } row_t;
   row_t tbl [18];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_ar = 0; m_pc = 0; m_dr = 0; m_ac = 0; m_ir = 0; m_tr = 0; m_e = 0;
      m_md = 0; m_mdk = 1; m_err = 0; m_done = 0; m_pend = 0;
   endfunction

   function automatic int unsigned bus_model(input logic [2:0] sel);
      case (sel)
         3'd1: return m_ar;
         3'd2: return m_pc;
         3'd3: return m_dr;
         3'd4: return m_ac;
         3'd5: return m_ir;
         3'd6: return m_tr;
         3'd7: return m_md;
         default: return 0;
      endcase
   endfunction

   function automatic void alu_model(input logic [2:0] op, output int unsigned res,
                                     output int unsigned eo, output bit co, output bit ovf);
      int sa, sd;
      int unsigned v;
      sa = (m_ac >= 32768) ? int'(m_ac) - 65536 : int'(m_ac);
      sd = (m_dr >= 32768) ? int'(m_dr) - 65536 : int'(m_dr);
      eo = m_e; co = 0; ovf = 0; res = m_ac;
      case (op)
         3'd0: res = m_ac & m_dr;
         3'd1: begin
            v = m_ac + m_dr; res = v % 65536; eo = v / 65536; co = eo[0];
            ovf = (sa + sd > 32767) || (sa + sd < -32768);
         end
         3'd2: res = m_dr;
         3'd3: res = 65535 - m_ac;
         3'd4: begin
            v = m_e * 65536 + m_ac; v = v / 2 + (v % 2) * 65536;
            res = v % 65536; eo = v / 65536;
         end
         3'd5: begin
            v = m_e * 65536 + m_ac; v = (v * 2) % 131072 + v / 65536;
            res = v % 65536; eo = v / 65536;
         end
         3'd6: res = m_ac;
         default: begin
            v = m_ac + 1; res = v % 65536; eo = v / 65536; co = eo[0];
            ovf = (sa + 1 > 32767);
         end
      endcase
   endfunction

   function automatic int unsigned upd(input bit c, input bit l, input bit i, input int unsigned cur,
                                       input int unsigned lv, input int unsigned modv);
      if (c) return 0;
      if (l) return lv % modv;
      if (i) return (cur + 1) % modv;
      return cur;
   endfunction

   task automatic check_regs();
      chk("AR", AR, m_ar);   chk("PC", PC, m_pc);   chk("DR", DR, m_dr);
      chk("AC", AC, m_ac);   chk("IR", IR, m_ir);   chk("TR", TR, m_tr);
      chk("E", E, m_e);      chk("mem_busy", mem_busy, m_pend);
      chk("mem_done", mem_done, m_done);            chk("mem_err", mem_err, m_err);
      if (m_mdk) chk("MDATA", MDATA, m_md);
   endtask

   // Drive one cycle from a negedge, step the model across the posedge, check at next negedge
   task automatic cycle(input logic [2:0] sel, input logic [6:0] l, input logic [6:0] i,
                        input logic [6:0] c, input logic [2:0] op, input logic rd, input logic wr);
      int unsigned bus, res, eo, n_md;
      bit co, ovf, n_done, n_mdk, was_busy;
      bus_sel = sel; ld = l; inc = i; clr = c; alu_op = op; mem_rd = rd; mem_wr = wr;
      #1;
      bus = bus_model(sel);
      alu_model(op, res, eo, co, ovf);
      last_flags = {CO, OVF, Z, N};
      chk("CO", CO, co); chk("OVF", OVF, ovf);
      chk("Z", Z, (res == 0)); chk("N", N, (res >= 32768));
      cyc++;
      n_done = 0; n_md = m_md; n_mdk = m_mdk; was_busy = m_pend;
      if (m_pend && cyc == m_ta + LAT) begin
         if (m_pwr) mmem[m_paddr] = m_pdata[15:0];
         else if (mmem.exists(m_paddr)) begin n_md = mmem[m_paddr]; n_mdk = 1; end
         else n_mdk = 0;
         n_done = 1; m_pend = 0;
      end
      if (was_busy) begin
         if (rd || wr) m_err = 1;
      end else if (rd && wr) m_err = 1;
      else if (rd || wr) begin
         m_pend = 1; m_ta = cyc; m_pwr = wr; m_paddr = m_ar; m_pdata = bus;
      end
      @(posedge clk);
      m_ar = upd(c[0], l[0], i[0], m_ar, bus, 4096);
      m_pc = upd(c[1], l[1], i[1], m_pc, bus, 4096);
      m_dr = upd(c[2], l[2], i[2], m_dr, bus, 65536);
      m_ac = upd(c[3], l[3], i[3], m_ac, res, 65536);
      m_ir = upd(c[4], l[4], 1'b0, m_ir, bus, 65536);
      m_tr = upd(c[5], l[5], 1'b0, m_tr, bus, 65536);
      m_e  = upd(c[6], l[6], i[6], m_e, eo, 2);
      m_md = n_md; m_mdk = n_mdk; m_done = n_done;
      @(negedge clk);
      check_regs();
   endtask

   task automatic idle();
      cycle(3'd0, 7'h00, 7'h00, 7'h00, 3'd6, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      bus_sel = 3'd0; ld = 7'h00; inc = 7'h00; clr = 7'h00; alu_op = 3'd0;
      mem_rd = 1'b0; mem_wr = 1'b0;
      model_reset();
      #1 check_regs();
      @(posedge clk);
      @(negedge clk);
      check_regs();
      reset_n = 1'b1;
   endtask

   // Build an arbitrary AC value by rotating bits in through E
   task automatic set_ac(input logic [15:0] v);
      cycle(3'd0, 7'h00, 7'h00, 7'h48, 3'd6, 1'b0, 1'b0);
      for (int b = 15; b >= 0; b--) begin
         if (v[b]) cycle(3'd0, 7'h00, 7'h40, 7'h00, 3'd6, 1'b0, 1'b0);
         cycle(3'd0, 7'h48, 7'h00, 7'h00, 3'd5, 1'b0, 1'b0);
      end
   endtask

   task automatic load_ar(input logic [15:0] v);
      set_ac(v);
      cycle(3'd4, 7'h01, 7'h00, 7'h00, 3'd6, 1'b0, 1'b0);
   endtask

   initial begin
      logic [2:0] rs, rop;
      logic [6:0] rl, ri, rc;
      tbl[0]  = '{3'd0, 7'h00, 7'h00, 7'h7F, 3'd6, 4'b0010, 16'h0000, 1'b0, 16'h0000, 12'h000};
      tbl[1]  = '{3'd0, 7'h08, 7'h00, 7'h00, 3'd3, 4'b0001, 16'hFFFF, 1'b0, 16'h0000, 12'h000};
      tbl[2]  = '{3'd0, 7'h48, 7'h00, 7'h00, 3'd4, 4'b0000, 16'h7FFF, 1'b1, 16'h0000, 12'h000};
      tbl[3]  = '{3'd0, 7'h00, 7'h04, 7'h40, 3'd6, 4'b0000, 16'h7FFF, 1'b0, 16'h0001, 12'h000};
      tbl[4]  = '{3'd0, 7'h48, 7'h00, 7'h00, 3'd1, 4'b0101, 16'h8000, 1'b0, 16'h0001, 12'h000};
      tbl[5]  = '{3'd0, 7'h00, 7'h00, 7'h08, 3'd6, 4'b0001, 16'h0000, 1'b0, 16'h0001, 12'h000};
      tbl[6]  = '{3'd0, 7'h08, 7'h00, 7'h00, 3'd3, 4'b0001, 16'hFFFF, 1'b0, 16'h0001, 12'h000};
      tbl[7]  = '{3'd0, 7'h48, 7'h00, 7'h00, 3'd7, 4'b1010, 16'h0000, 1'b1, 16'h0001, 12'h000};
      tbl[8]  = '{3'd0, 7'h48, 7'h00, 7'h00, 3'd4, 4'b0001, 16'h8000, 1'b0, 16'h0001, 12'h000};
      tbl[9]  = '{3'd0, 7'h48, 7'h00, 7'h00, 3'd1, 4'b0001, 16'h8001, 1'b0, 16'h0001, 12'h000};
      tbl[10] = '{3'd0, 7'h48, 7'h00, 7'h00, 3'd5, 4'b0000, 16'h0002, 1'b1, 16'h0001, 12'h000};
      tbl[11] = '{3'd0, 7'h48, 7'h00, 7'h00, 3'd4, 4'b0001, 16'h8001, 1'b0, 16'h0001, 12'h000};
      tbl[12] = '{3'd0, 7'h08, 7'h00, 7'h00, 3'd3, 4'b0000, 16'h7FFE, 1'b0, 16'h0001, 12'h000};
      tbl[13] = '{3'd4, 7'h02, 7'h00, 7'h00, 3'd6, 4'b0000, 16'h7FFE, 1'b0, 16'h0001, 12'hFFE};
      tbl[14] = '{3'd0, 7'h00, 7'h02, 7'h00, 3'd6, 4'b0000, 16'h7FFE, 1'b0, 16'h0001, 12'hFFF};
      tbl[15] = '{3'd0, 7'h00, 7'h02, 7'h00, 3'd6, 4'b0000, 16'h7FFE, 1'b0, 16'h0001, 12'h000};
      tbl[16] = '{3'd4, 7'h02, 7'h00, 7'h00, 3'd6, 4'b0000, 16'h7FFE, 1'b0, 16'h0001, 12'hFFE};
      tbl[17] = '{3'd4, 7'h02, 7'h02, 7'h02, 3'd6, 4'b0000, 16'h7FFE, 1'b0, 16'h0001, 12'h000};

      cyc = 0;
      reset_n = 1'b0;
      bus_sel = 3'd0; ld = 7'h00; inc = 7'h00; clr = 7'h00; alu_op = 3'd0;
      mem_rd = 1'b0; mem_wr = 1'b0;
      model_reset();
      @(negedge clk);
      check_regs();
      @(negedge clk);
      reset_n = 1'b1;

      // ALU / register table
      for (int k = 0; k < 18; k++) begin
         cycle(tbl[k].sel, tbl[k].l, tbl[k].i, tbl[k].c, tbl[k].op, 1'b0, 1'b0);
         chk("tbl_flags", last_flags, tbl[k].flg);
         chk("tbl_AC", AC, tbl[k].ac);
         chk("tbl_E", E, tbl[k].e);
         chk("tbl_DR", DR, tbl[k].dr);
         chk("tbl_PC", PC, tbl[k].pc);
      end

      // write then read back, back-to-back issue, request while busy
      load_ar(16'h0005);
      chk("ar_005", AR, 12'h005);
      set_ac(16'hBEEF);
      cycle(3'd4, 7'h00, 7'h00, 7'h00, 3'd6, 1'b0, 1'b1);
      chk("wr_busy_c1", mem_busy, 1'b1);
      idle();
      chk("wr_busy_c2", mem_busy, 1'b1); chk("wr_nodone_c2", mem_done, 1'b0);
      idle();
      chk("wr_done", mem_done, 1'b1);    chk("wr_idle", mem_busy, 1'b0);
      cycle(3'd0, 7'h00, 7'h00, 7'h00, 3'd6, 1'b1, 1'b0);
      idle();
      idle();
      chk("rd_done", mem_done, 1'b1);    chk("rd_data", MDATA, 16'hBEEF);
      cycle(3'd7, 7'h04, 7'h00, 7'h00, 3'd6, 1'b1, 1'b0);
      chk("dr_from_mdata", DR, 16'hBEEF); chk("b2b_busy", mem_busy, 1'b1);
      chk("b2b_noerr", mem_err, 1'b0);
      cycle(3'd0, 7'h00, 7'h00, 7'h00, 3'd6, 1'b1, 1'b0);
      chk("busy_req_err", mem_err, 1'b1); chk("busy_req_nodone", mem_done, 1'b0);
      idle();
      chk("busy_req_done", mem_done, 1'b1);

      do_reset();
      cycle(3'd0, 7'h00, 7'h00, 7'h00, 3'd6, 1'b1, 1'b1);
      chk("both_err", mem_err, 1'b1);     chk("both_idle", mem_busy, 1'b0);
      idle();
      chk("both_nodone", mem_done, 1'b0);

      // reset in the middle of a write aborts it
      do_reset();
      load_ar(16'h0010);
      set_ac(16'hAAAA);
      cycle(3'd4, 7'h00, 7'h00, 7'h00, 3'd6, 1'b0, 1'b1);
      idle();
      idle();
      chk("pre_wr_done", mem_done, 1'b1);
      set_ac(16'h1234);
      cycle(3'd4, 7'h00, 7'h00, 7'h00, 3'd6, 1'b0, 1'b1);
      idle();
      do_reset();
      chk("abort_nodone", mem_done, 1'b0);
      idle();
      chk("abort_nodone2", mem_done, 1'b0);
      load_ar(16'h0010);
      cycle(3'd0, 7'h00, 7'h00, 7'h00, 3'd6, 1'b1, 1'b0);
      idle();
      idle();
      chk("abort_rd_data", MDATA, 16'hAAAA);

      // randomized traffic
      for (int k = 0; k < 2000; k++) begin
         if ($urandom_range(0, 399) == 0) do_reset();
         rs = 3'($urandom_range(0, 7));
         if (rs == 3'd7 && !m_mdk) rs = 3'd4;
         rl  = 7'($urandom);
         ri  = 7'($urandom);
         rc  = 7'($urandom & $urandom & $urandom);
         rop = 3'($urandom_range(0, 7));
         cycle(rs, rl, ri, rc, rop, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/param_datapath.md
PARAM_DATAPATH -- requirements
Module: param_datapath

Interface
REQ-001 Parameter W, default 16, data/bus width (8..32).
REQ-002 Parameter AW, default 12, address width; memory depth 2**AW words.
REQ-003 Parameter MEM_LAT, default 2, memory access latency in cycles (1..7).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 bus_sel  in  3  bus source: 0 zero, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MDATA.
REQ-007 ld, inc, clr  in  7 each  per-register controls, bit 0 AR, 1 PC, 2 DR, 3 AC, 4 IR, 5 TR, 6 E.
REQ-008 alu_op  in  3  ALU operation select.
REQ-009 mem_rd, mem_wr  in  1 each  memory access request, sampled one cycle.
REQ-010 mem_busy, mem_done, mem_err  out  1 each  access in flight, completion pulse, sticky request error.
REQ-011 AR, PC  out  AW; DR, AC, IR, TR, MDATA  out  W; E  out  1.
REQ-012 CO, OVF, Z, N  out  1  combinational ALU flags.

Function
REQ-013 Bus SHALL be combinational from bus_sel; AR/PC sources zero-extended to W.
REQ-014 AR, PC SHALL load bus[AW-1:0]; DR, IR, TR SHALL load bus; AC, E SHALL load ALU result, ALU E-out.
REQ-015 Per register, priority SHALL be clr > ld > inc; inc wraps modulo 2**width; IR, TR ignore inc.
REQ-016 ALU ops: 0 AC&DR; 1 AC+DR, E-out=carry; 2 DR; 3 ~AC; 4 rotate right {E,AC}, E-out=AC[0]; 5 rotate left, E-out=AC[W-1]; 6 AC; 7 AC+1, E-out=carry.
REQ-017 For ops other than 1,4,5,7, E-out SHALL equal E.
REQ-018 CO = carry of ops 1/7 else 0; OVF = signed overflow of ops 1/7 else 0; Z = (result==0); N = result[W-1].
REQ-019 Memory FSM states IDLE, BUSY; mem_busy=1 exactly in BUSY.
REQ-020 In IDLE, exactly one of mem_rd/mem_wr high SHALL capture AR as address, bus as write data, op type, load counter MEM_LAT-1, go BUSY.
REQ-021 BUSY SHALL decrement counter each cycle; at counter 0 return to IDLE and pulse mem_done for one cycle.
REQ-022 Request sampled at edge t SHALL yield mem_done high during cycle t+MEM_LAT (MEM_LAT=1: next cycle).
REQ-023 Read: MDATA SHALL update with mem[captured addr] on the edge that raises mem_done; MDATA holds otherwise.
REQ-024 Write: array SHALL commit on the edge that raises mem_done; MDATA unchanged.
REQ-025 Captured address/data SHALL be used; AR/bus changes during BUSY have no effect.
REQ-026 mem_rd and mem_wr both high, or any request while BUSY, SHALL be ignored and set mem_err; FSM unaffected.
REQ-027 A new request is accepted in the cycle mem_done is high (FSM already IDLE): back-to-back throughput one access per MEM_LAT+... cycles with zero idle gap.
REQ-028 Register loads from bus_sel=7 in the mem_done cycle SHALL see the new MDATA.

Reset
REQ-029 reset_n low SHALL asynchronously clear AR, PC, DR, AC, IR, TR, E, MDATA, counter, mem_done, mem_err, and force IDLE.
REQ-030 Reset mid-access SHALL abort it: no array write, no mem_done pulse.
REQ-031 Memory array contents SHALL NOT be cleared by reset.

Verification
REQ-032 W=16, AW=12, MEM_LAT=2: AR=0x005, bus=0xBEEF (AC), mem_wr -> mem_busy 2 cycles, mem_done cycle t+2; then mem_rd @0x005 -> MDATA=0xBEEF at done.
REQ-033 AC=0x7FFF, DR=0x0001, op 1, ld AC/E -> AC=0x8000, E=0, OVF=1, N=1, CO=0; AC=0xFFFF, op 7 -> AC=0, E=1, Z=1.
REQ-034 AC=0x8001, E=0, op 5 -> AC=0x0002, E=1; then op 4 -> AC=0x8001, E=0.
REQ-035 mem_rd during BUSY, and mem_rd+mem_wr in IDLE -> both ignored, mem_err=1, in-flight done timing unchanged.
REQ-036 mem_wr to 0x010 data 0x1234, reset_n low at t+1 -> no done pulse; later read 0x010 returns prior contents, not 0x1234.
REQ-037 PC=0xFFF, inc[1] -> PC=0x000; clr[1]+ld[1]+inc[1] together -> PC=0.
